pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID/EX pipeline around the decode stage: detects load-use hazards, converts PC redirects
//  into flush windows, and implements debug halt/single-step. Drives the bubble select (inHazard) of the
//  decode control mux, PC/IF-ID write enables and the flush controls. Keeps saturating stall/flush counters.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles IF/ID+ID/EX are flushed after a taken branch (1..7)
//  CNT_W         16  width of stall_count / flush_count
// PORTS
//  clk          in   1      pipeline clock, all state on rising edge
//  reset        in   1      synchronous, active-low reset
//  ifid_rs      in   5      rs field (Instruction[25:21]) of instruction in ID
//  ifid_rt      in   5      rt field (Instruction[20:16]) of instruction in ID
//  idex_memread in   1      MemRead of instruction in EX
//  idex_rt      in   5      destination rt of instruction in EX
//  pc_src       in   1      taken branch resolved (redirect)
//  jump_flag    in   1      jump decoded in ID
//  dbg_halt     in   1      level: request halt
//  dbg_step     in   1      pulse: advance one instruction while halted
//  in_hazard    out  1      1 = decode control mux emits bubble
//  pc_write     out  1      PC update enable
//  ifid_write   out  1      IF/ID register update enable
//  ifid_flush   out  1      clear IF/ID this cycle
//  idex_flush   out  1      clear ID/EX this cycle
//  halted       out  1      FSM in HALT
//  stall_count  out  CNT_W  saturating count of load-use stall cycles
//  flush_count  out  CNT_W  saturating count of flush cycles
// BEHAVIOUR
//  States: RUN, FLUSH, HALT, STEP. Reset (reset==0 at clk edge): state=RUN, flush counter=0, counters=0.
//  Outputs are combinational from state+inputs; with reset low they read in_hazard=0, pc_write=1, ifid_write=1,
//  flushes=0, halted=0.
//  load_use = idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || idex_rt==ifid_rt).
//  RUN: default pc_write=ifid_write=1, in_hazard=0.
//   - pc_src: ifid_flush=idex_flush=1, in_hazard=1; if FLUSH_CYCLES>1 go FLUSH with remaining=FLUSH_CYCLES-1.
//   - else load_use: in_hazard=1, pc_write=0, ifid_write=0 for exactly this cycle; stall_count++.
//   - else jump_flag: ifid_flush=1 only (one cycle, no bubble).
//   - dbg_halt sampled high (and no pc_src): next state HALT; current cycle completes normally.
//  Priority: pc_src > load_use > jump_flag; pc_src always wins over dbg_halt (redirect completes first,
//  halt taken on exit of RUN/FLUSH).
//  FLUSH: ifid_flush=idex_flush=in_hazard=1, pc_write=1; decrement remaining; at 0 -> HALT if dbg_halt
//   else RUN. A new pc_src in FLUSH reloads remaining=FLUSH_CYCLES-1.
//  HALT: pc_write=ifid_write=0, in_hazard=1, halted=1. dbg_halt low -> RUN. dbg_step high (halt still high)
//   -> STEP. Load-use ignored while halted.
//  STEP: one RUN-equivalent cycle (same hazard/flush rules), then HALT. If that cycle has load_use, stay in
//   STEP one more cycle so exactly one instruction leaves ID. pc_src in STEP -> FLUSH, then HALT.
//  flush_count++ on every cycle idex_flush=1. Both counters saturate at all-ones, never wrap.
//  Reset mid-FLUSH/HALT/STEP: returns to RUN next edge, remaining cleared.
// TESTING
//  1 lw $2 in EX (idex_memread=1, idex_rt=2), ID rs=2 -> one cycle pc_write=0,ifid_write=0,in_hazard=1;
//    next cycle normal; stall_count=1.
//  2 idex_rt=0 with rs=0, memread=1 -> no stall, stall_count stays 0.
//  3 FLUSH_CYCLES=3, pc_src pulse -> idex_flush high 3 consecutive cycles, flush_count=3, then RUN.
//  4 pc_src and load_use same cycle -> flush only, stall_count unchanged.
//  5 dbg_halt=1 -> halted=1 next cycle, pc_write=0; 3 dbg_step pulses -> exactly 3 PC advances; halt=0 -> RUN.
//  6 reset=0 asserted while in FLUSH (remaining=2) -> next cycle RUN, all flushes 0, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Sequences the IF/ID/EX pipeline around the decode stage. It detects
//   load-use hazards, turns PC redirects into flush windows and implements
//   debug halt / single-step. It also keeps saturating counters of stall
//   cycles and flush cycles.
//
// Parameters
//   FLUSH_CYCLES  cycles IF/ID and ID/EX are flushed after a taken branch (1..7)
//   CNT_W         width of stall_count / flush_count
//
// Ports
//   clk           pipeline clock; all state changes on the rising edge
//   reset         synchronous, active-low reset
//   ifid_rs       rs field of the instruction in ID
//   ifid_rt       rt field of the instruction in ID
//   idex_memread  MemRead of the instruction in EX
//   idex_rt       destination rt of the instruction in EX
//   pc_src        taken branch resolved (redirect)
//   jump_flag     jump decoded in ID
//   dbg_halt      level: request halt
//   dbg_step      pulse: advance one instruction while halted
//   in_hazard     1 = decode control mux emits a bubble
//   pc_write      PC update enable
//   ifid_write    IF/ID register update enable
//   ifid_flush    clear IF/ID this cycle
//   idex_flush    clear ID/EX this cycle
//   halted        controller is in HALT
//   stall_count   saturating count of load-use stall cycles
//   flush_count   saturating count of cycles with idex_flush high
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             pc_src,
  input  logic             jump_flag,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic             in_hazard,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2,
    STEP  = 2'd3
  } ctrlStateT;

  // Number of extra flush cycles after the redirect cycle itself.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  ctrlStateT  state, nextState;
  logic [2:0] flushLeft, nextFlushLeft;
  logic       haltAfterFlush, nextHaltAfterFlush;
  logic       loadUse;
  logic       stallCycle;

  // Register 0 is hard-wired to zero, so a load "into" it never creates a hazard.
  assign loadUse = idex_memread && (idex_rt != 5'd0) &&
                   ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    nextState          = state;
    nextFlushLeft      = flushLeft;
    nextHaltAfterFlush = haltAfterFlush;
    in_hazard          = 1'b0;
    pc_write           = 1'b1;
    ifid_write         = 1'b1;
    ifid_flush         = 1'b0;
    idex_flush         = 1'b0;
    halted             = 1'b0;
    stallCycle         = 1'b0;

    case (state)
      // STEP behaves exactly like RUN for one instruction, then returns to HALT.
      RUN, STEP: begin
        if (pc_src) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          in_hazard  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            nextState          = FLUSH;
            nextFlushLeft      = FLUSH_RELOAD;
            nextHaltAfterFlush = (state == STEP);
          end else begin
            nextState = (state == STEP) ? HALT : RUN;
          end
        end else begin
          if (loadUse) begin
            in_hazard  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stallCycle = 1'b1;
          end else if (jump_flag) begin
            ifid_flush = 1'b1;
          end

          if (state == RUN) begin
            if (dbg_halt) nextState = HALT;
          end else begin
            // A stalled step has not yet moved its instruction out of ID.
            nextState = loadUse ? STEP : HALT;
          end
        end
      end

      FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        in_hazard  = 1'b1;
        if (pc_src) begin
          nextFlushLeft = FLUSH_RELOAD;
        end else if (flushLeft <= 3'd1) begin
          nextFlushLeft      = 3'd0;
          nextHaltAfterFlush = 1'b0;
          nextState          = (dbg_halt || haltAfterFlush) ? HALT : RUN;
        end else begin
          nextFlushLeft = flushLeft - 3'd1;
        end
      end

      HALT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        in_hazard  = 1'b1;
        halted     = 1'b1;
        if (!dbg_halt)     nextState = RUN;
        else if (dbg_step) nextState = STEP;
      end

      default: nextState = RUN;
    endcase

    // While reset is held the pipeline sees plain run-mode controls.
    if (!reset) begin
      in_hazard  = 1'b0;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = 1'b0;
      stallCycle = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= RUN;
      flushLeft      <= 3'd0;
      haltAfterFlush <= 1'b0;
      stall_count    <= '0;
      flush_count    <= '0;
    end else begin
      state          <= nextState;
      flushLeft      <= nextFlushLeft;
      haltAfterFlush <= nextHaltAfterFlush;
      if (stallCycle && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (idex_flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed vectors with hand-computed expectations. The stimulus process
//   drives one vector per cycle and pushes its expected outputs into a queue;
//   the monitor pops one entry on each falling edge and compares.
//   Small counters (CNT_W=3) make saturation reachable; FLUSH_CYCLES=3.
//   Output code order: {in_hazard, pc_write, ifid_write, ifid_flush, idex_flush, halted}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 3;

  // Hand-computed output codes.
  localparam logic [5:0] O_NORM  = 6'b011000;
  localparam logic [5:0] O_STALL = 6'b100000;
  localparam logic [5:0] O_FLUSH = 6'b111110;
  localparam logic [5:0] O_JUMP  = 6'b011100;
  localparam logic [5:0] O_HALT  = 6'b100001;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [4:0]       ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic             idex_memread = 1'b0, pc_src = 1'b0, jump_flag = 1'b0;
  logic             dbg_halt = 1'b0, dbg_step = 1'b0;
  logic             in_hazard, pc_write, ifid_write, ifid_flush, idex_flush, halted;
  logic [CNT_W-1:0] stall_count, flush_count;

  typedef struct {
    string      name;
    logic [5:0] outs;
    int         stallCnt;
    int         flushCnt;
  } expT;

  expT expQ[$];
  int  checkCount = 0;
  int  passCount  = 0;
  int  failCount  = 0;
  bit  stimDone   = 1'b0;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .idex_memread(idex_memread),
    .idex_rt     (idex_rt),
    .pc_src      (pc_src),
    .jump_flag   (jump_flag),
    .dbg_halt    (dbg_halt),
    .dbg_step    (dbg_step),
    .in_hazard   (in_hazard),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .halted      (halted),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, actual, expected);
    end
  endtask

  // One cycle of stimulus plus its expected response.
  task automatic cyc(input string nm, input logic rstV,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic mr, input logic [4:0] ert,
                     input logic br, input logic jmp,
                     input logic hlt, input logic stp,
                     input logic [5:0] outs, input int sc, input int fc);
    expT e;
    @(posedge clk);
    #1;
    reset        = rstV;
    ifid_rs      = rs;
    ifid_rt      = rt;
    idex_memread = mr;
    idex_rt      = ert;
    pc_src       = br;
    jump_flag    = jmp;
    dbg_halt     = hlt;
    dbg_step     = stp;
    e.name       = nm;
    e.outs       = outs;
    e.stallCnt   = sc;
    e.flushCnt   = fc;
    expQ.push_back(e);
  endtask

  // Monitor: compares the combinational outputs and counters mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      check({e.name, ".outs"},
            int'({in_hazard, pc_write, ifid_write, ifid_flush, idex_flush, halted}),
            int'(e.outs));
      check({e.name, ".counts"},
            int'({stall_count, flush_count}),
            (e.stallCnt << CNT_W) | e.flushCnt);
    end
  end

  initial begin
    //   name           rst rs     rt     mr  ert    br jmp hlt stp  outs     S  F
    cyc("reset",         0, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  0, 0);
    cyc("idle",          1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  0, 0);
    // load-use on rs
    cyc("lu_rs",         1, 5'd2,  5'd7,  1, 5'd2,  0, 0,  0,  0, O_STALL, 0, 0);
    cyc("lu_after",      1, 5'd2,  5'd7,  0, 5'd2,  0, 0,  0,  0, O_NORM,  1, 0);
    // register zero never stalls
    cyc("lu_r0",         1, 5'd0,  5'd0,  1, 5'd0,  0, 0,  0,  0, O_NORM,  1, 0);
    // load-use on rt
    cyc("lu_rt",         1, 5'd1,  5'd5,  1, 5'd5,  0, 0,  0,  0, O_STALL, 1, 0);
    cyc("lu_rt_after",   1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  2, 0);
    // match without MemRead
    cyc("no_memread",    1, 5'd3,  5'd0,  0, 5'd3,  0, 0,  0,  0, O_NORM,  2, 0);
    // taken branch -> 3 flush cycles
    cyc("br0",           1, 5'd0,  5'd0,  0, 5'd0,  1, 0,  0,  0, O_FLUSH, 2, 0);
    cyc("br1",           1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_FLUSH, 2, 1);
    cyc("br2",           1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_FLUSH, 2, 2);
    cyc("br_done",       1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  2, 3);
    // branch beats load-use; load-use ignored during flush
    cyc("br_lu0",        1, 5'd4,  5'd0,  1, 5'd4,  1, 0,  0,  0, O_FLUSH, 2, 3);
    cyc("br_lu1",        1, 5'd4,  5'd0,  1, 5'd4,  0, 0,  0,  0, O_FLUSH, 2, 4);
    cyc("br_lu2",        1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_FLUSH, 2, 5);
    cyc("br_lu_done",    1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  2, 6);
    // jump flushes IF/ID only; load-use beats jump
    cyc("jump",          1, 5'd0,  5'd0,  0, 5'd0,  0, 1,  0,  0, O_JUMP,  2, 6);
    cyc("jump_lu",       1, 5'd6,  5'd0,  1, 5'd6,  0, 1,  0,  0, O_STALL, 2, 6);
    cyc("jump_lu_after", 1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  3, 6);
    // flush counter saturates at 7
    cyc("sat0",          1, 5'd0,  5'd0,  0, 5'd0,  1, 0,  0,  0, O_FLUSH, 3, 6);
    cyc("sat1",          1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_FLUSH, 3, 7);
    cyc("sat2",          1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_FLUSH, 3, 7);
    cyc("sat_done",      1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  3, 7);
    // branch during FLUSH reloads the window
    cyc("rl0",           1, 5'd0,  5'd0,  0, 5'd0,  1, 0,  0,  0, O_FLUSH, 3, 7);
    cyc("rl1",           1, 5'd0,  5'd0,  0, 5'd0,  1, 0,  0,  0, O_FLUSH, 3, 7);
    cyc("rl2",           1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_FLUSH, 3, 7);
    cyc("rl3",           1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_FLUSH, 3, 7);
    cyc("rl_done",       1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  3, 7);
    // debug halt and three single steps
    cyc("halt_req",      1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_NORM,  3, 7);
    cyc("halted",        1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_HALT,  3, 7);
    cyc("step1_req",     1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  1, O_HALT,  3, 7);
    cyc("step1",         1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_NORM,  3, 7);
    cyc("step1_halt",    1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_HALT,  3, 7);
    cyc("step2_req",     1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  1, O_HALT,  3, 7);
    cyc("step2_stall",   1, 5'd8,  5'd0,  1, 5'd8,  0, 0,  1,  0, O_STALL, 3, 7);
    cyc("step2",         1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_NORM,  4, 7);
    cyc("step2_halt",    1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_HALT,  4, 7);
    cyc("step3_req",     1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  1, O_HALT,  4, 7);
    cyc("step3",         1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_NORM,  4, 7);
    cyc("halt_lu",       1, 5'd9,  5'd0,  1, 5'd9,  0, 0,  1,  0, O_HALT,  4, 7);
    cyc("unhalt",        1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_HALT,  4, 7);
    cyc("resumed",       1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  4, 7);
    // reset in the middle of a flush window
    cyc("rst_br",        1, 5'd0,  5'd0,  0, 5'd0,  1, 0,  0,  0, O_FLUSH, 4, 7);
    cyc("rst_in_flush",  0, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  4, 7);
    cyc("rst_after",     1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  0, 0);
    cyc("rst_after2",    1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  0, 0);
    // branch during a step flushes, then returns to HALT
    cyc("sb_halt_req",   1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_NORM,  0, 0);
    cyc("sb_halted",     1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_HALT,  0, 0);
    cyc("sb_step_req",   1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  1, O_HALT,  0, 0);
    cyc("sb_step_br",    1, 5'd0,  5'd0,  0, 5'd0,  1, 0,  1,  0, O_FLUSH, 0, 0);
    cyc("sb_flush1",     1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_FLUSH, 0, 1);
    cyc("sb_flush2",     1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_FLUSH, 0, 2);
    cyc("sb_rehalt",     1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  1,  0, O_HALT,  0, 3);
    cyc("sb_unhalt",     1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_HALT,  0, 3);
    cyc("sb_resumed",    1, 5'd0,  5'd0,  0, 5'd0,  0, 0,  0,  0, O_NORM,  0, 3);

    // Let the monitor drain, bounded by a cycle budget.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    check("queue_drained", expQ.size(), 0);
    stimDone = 1'b1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #50000;
    if (!stimDone) begin
      $display("FAIL watchdog: simulation did not complete, %0d entries pending", expQ.size());
      $fatal(1);
    end
  end

endmodule
